// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with a one-entry holding buffer, a bit-rate
// enable and per-frame first/last flags. Back-to-back frames run gap-free.
module piso_serializer #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             bit_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hold_reg;
  logic [WIDTH-1:0] shift, shift_nx;
  logic             hold_full, hold_full_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             sout_nx, valid_nx, first_nx, last_nx;
  logic             accept, start;

  // State register (datapath registers live alongside the FSM state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_reg   <= '0;
      hold_full  <= 1'b0;
      shift      <= '0;
      cnt        <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_full  <= hold_full_nx;
      shift      <= shift_nx;
      cnt        <= cnt_nx;
      sout       <= sout_nx;
      sout_valid <= valid_nx;
      sout_first <= first_nx;
      sout_last  <= last_nx;
      if (accept) hold_reg <= load_data;
    end
  end

  // Next-state logic; the shifter keeps the bit on sout at its output end so
  // each advance emits the neighbour and shifts by one.
  always_comb begin
    state_nx     = state;
    hold_full_nx = hold_full;
    shift_nx     = shift;
    cnt_nx       = cnt;
    sout_nx      = sout;
    valid_nx     = sout_valid;
    first_nx     = sout_first;
    last_nx      = sout_last;
    start        = 1'b0;

    if (accept) hold_full_nx = 1'b1;

    if (bit_en) begin
      case (state)
        IDLE: begin
          if (hold_full) start = 1'b1;
          else           sout_nx = IDLE_LEVEL;
        end
        SHIFT: begin
          if (cnt != CW'(WIDTH)) begin
            if (LSB_FIRST) begin
              sout_nx  = shift[1];
              shift_nx = shift >> 1;
            end else begin
              sout_nx  = shift[WIDTH-2];
              shift_nx = shift << 1;
            end
            first_nx = 1'b0;
            last_nx  = (cnt == CW'(WIDTH - 1));
            cnt_nx   = cnt + 1'b1;
          end else if (hold_full) begin
            start = 1'b1;
          end else begin
            state_nx = IDLE;
            sout_nx  = IDLE_LEVEL;
            valid_nx = 1'b0;
            first_nx = 1'b0;
            last_nx  = 1'b0;
            cnt_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase

      if (start) begin
        state_nx     = SHIFT;
        hold_full_nx = 1'b0;
        shift_nx     = hold_reg;
        sout_nx      = LSB_FIRST ? hold_reg[0] : hold_reg[WIDTH-1];
        valid_nx     = 1'b1;
        first_nx     = 1'b1;
        last_nx      = 1'b0;
        cnt_nx       = CW'(1);
      end
    end
  end

  // Combinational outputs
  always_comb begin
    load_ready = !hold_full;
    busy       = sout_valid | hold_full;
    accept     = load_valid & !hold_full;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializer configurations driven with random and
// directed traffic; a monitor per instance checks every bit slot.
module tb_piso_serializer;

  typedef struct {
    bit b;
    bit f;
    bit l;
    int acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q [2][$];
  bit   en_q [2];
  bit   live [2];
  bit   hp   [2];
  int   prev [2];

  // Instance A: WIDTH=16, MSB first, idle low
  logic        rst_n_a, lv_a, be_a, rdy_a, so_a, sv_a, sf_a, sl_a, bz_a;
  logic [15:0] ld_a;
  bit          lr_a, acc_a;
  int          per_a, ph_a;

  piso_serializer #(.WIDTH(16), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .load_valid(lv_a), .load_ready(rdy_a),
    .load_data(ld_a), .bit_en(be_a), .sout(so_a), .sout_valid(sv_a),
    .sout_first(sf_a), .sout_last(sl_a), .busy(bz_a)
  );

  // Instance B: WIDTH=8, LSB first, idle high
  logic       rst_n_b, lv_b, be_b, rdy_b, so_b, sv_b, sf_b, sl_b, bz_b;
  logic [7:0] ld_b;
  bit         lr_b, acc_b;
  int         per_b, ph_b;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .load_valid(lv_b), .load_ready(rdy_b),
    .load_data(ld_b), .bit_en(be_b), .sout(so_b), .sout_valid(sv_b),
    .sout_first(sf_b), .sout_last(sl_b), .busy(bz_b)
  );

  function automatic void chk(input int id, input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s[%0d] at cycle %0d: got=%0d want=%0d", nm, id, cyc, act, want);
    end
  endfunction

  // Reference model: a word becomes WIDTH bits in transmit order
  function automatic void push_word(input int id, input logic [15:0] d, input int w,
                                    input bit lsb, input int acc);
    exp_t e;
    for (int i = 0; i < w; i++) begin
      e.b   = lsb ? d[i] : d[w-1-i];
      e.f   = (i == 0);
      e.l   = (i == w - 1);
      e.acc = acc;
      q[id].push_back(e);
    end
  endfunction

  task automatic check(input int id, input bit en, input logic so, input logic sv,
                       input logic sf, input logic sl, input logic rdy, input logic bz,
                       input bit idl);
    exp_t e;
    chk(id, "busy", int'(bz), int'(sv | !rdy));
    if (en) begin
      if (sv) begin
        if (q[id].size() == 0) begin
          chk(id, "extra_bit", 1, 0);
        end else begin
          e = q[id].pop_front();
          chk(id, "sout", int'(so), int'(e.b));
          chk(id, "first", int'(sf), int'(e.f));
          chk(id, "last", int'(sl), int'(e.l));
          if (e.f) chk(id, "start_after_accept", int'(e.acc < cyc), 1);
        end
      end else begin
        chk(id, "idle_level", int'(so), int'(idl));
        chk(id, "idle_first", int'(sf), 0);
        chk(id, "idle_last", int'(sl), 0);
        chk(id, "no_gap", int'(q[id].size() > 0 && q[id][0].acc < cyc), 0);
      end
    end else if (hp[id]) begin
      chk(id, "hold", int'({so, sv, sf, sl}), prev[id]);
    end
    prev[id] = int'({so, sv, sf, sl});
    hp[id]   = 1'b1;
  endtask

  always @(posedge clk) begin
    en_q[0] <= be_a;
    live[0] <= rst_n_a;
    en_q[1] <= be_b;
    live[1] <= rst_n_b;
  end

  always @(negedge clk) begin
    if (rst_n_a && live[0]) check(0, en_q[0], so_a, sv_a, sf_a, sl_a, rdy_a, bz_a, 1'b0);
    else hp[0] = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n_b && live[1]) check(1, en_q[1], so_b, sv_b, sf_b, sl_b, rdy_b, bz_b, 1'b1);
    else hp[1] = 1'b0;
  end

  // ---------------- instance A stimulus ----------------
  task automatic step_a();
    @(posedge clk);
    acc_a = rst_n_a && lv_a && lr_a;
    #1;
    if (acc_a) push_word(0, ld_a, 16, 1'b0, cyc);
    lr_a = rdy_a;
  endtask

  task automatic tick_a();
    if (per_a == 0) be_a = 1'($urandom_range(0, 1));
    else            be_a = ((ph_a % per_a) == 0);
    ph_a++;
    if (!lv_a) ld_a = 16'($urandom);
    step_a();
  endtask

  task automatic send_a(input logic [15:0] d);
    lv_a = 1'b1;
    ld_a = d;
    acc_a = 1'b0;
    for (int i = 0; i < 300 && !acc_a; i++) tick_a();
    chk(0, "accept_timeout", int'(acc_a), 1);
    lv_a = 1'b0;
  endtask

  task automatic drive_a();
    rst_n_a = 1'b0; lv_a = 1'b0; ld_a = '0; be_a = 1'b0;
    per_a = 1; ph_a = 0;
    repeat (3) @(posedge clk);
    #1;
    chk(0, "rst_sout", int'(so_a), 0);
    chk(0, "rst_valid", int'(sv_a), 0);
    chk(0, "rst_first", int'(sf_a), 0);
    chk(0, "rst_last", int'(sl_a), 0);
    chk(0, "rst_ready", int'(rdy_a), 1);
    chk(0, "rst_busy", int'(bz_a), 0);
    rst_n_a = 1'b1;
    lr_a = rdy_a;

    send_a(16'hA5C3);
    repeat (20) tick_a();
    chk(0, "after_frame_valid", int'(sv_a), 0);
    chk(0, "after_frame_busy", int'(bz_a), 0);
    chk(0, "after_frame_sout", int'(so_a), 0);

    send_a(16'hFFFF);
    send_a(16'h0001);
    repeat (40) tick_a();

    per_a = 4; ph_a = 0;
    send_a(16'h8000);
    repeat (80) tick_a();

    per_a = 0;
    repeat (400) begin
      if (!lv_a || acc_a) begin
        lv_a = ($urandom_range(0, 2) != 0);
        ld_a = 16'($urandom);
      end
      tick_a();
    end
    lv_a = 1'b0;
    per_a = 1;
    repeat (40) tick_a();
    chk(0, "drain", q[0].size(), 0);

    // Abort mid-frame with a second word buffered
    send_a(16'($urandom));
    send_a(16'($urandom));
    repeat (3) tick_a();
    chk(0, "buffered_before_reset", int'(rdy_a), 0);
    chk(0, "valid_before_reset", int'(sv_a), 1);
    #1 rst_n_a = 1'b0;
    #1;
    chk(0, "abort_sout", int'(so_a), 0);
    chk(0, "abort_valid", int'(sv_a), 0);
    chk(0, "abort_ready", int'(rdy_a), 1);
    chk(0, "abort_busy", int'(bz_a), 0);
    q[0].delete();
    repeat (2) @(posedge clk);
    #1 rst_n_a = 1'b1;
    lr_a = rdy_a;
    repeat (40) tick_a();
    chk(0, "post_reset_idle", int'(sv_a), 0);
  endtask

  // ---------------- instance B stimulus ----------------
  task automatic step_b();
    @(posedge clk);
    acc_b = rst_n_b && lv_b && lr_b;
    #1;
    if (acc_b) push_word(1, {8'h00, ld_b}, 8, 1'b1, cyc);
    lr_b = rdy_b;
  endtask

  task automatic tick_b();
    if (per_b == 0) be_b = 1'($urandom_range(0, 1));
    else            be_b = ((ph_b % per_b) == 0);
    ph_b++;
    if (!lv_b) ld_b = 8'($urandom);
    step_b();
  endtask

  task automatic send_b(input logic [7:0] d);
    lv_b = 1'b1;
    ld_b = d;
    acc_b = 1'b0;
    for (int i = 0; i < 300 && !acc_b; i++) tick_b();
    chk(1, "accept_timeout", int'(acc_b), 1);
    lv_b = 1'b0;
  endtask

  task automatic drive_b();
    rst_n_b = 1'b0; lv_b = 1'b0; ld_b = '0; be_b = 1'b0;
    per_b = 0; ph_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk(1, "rst_sout", int'(so_b), 1);
    chk(1, "rst_valid", int'(sv_b), 0);
    chk(1, "rst_ready", int'(rdy_b), 1);
    rst_n_b = 1'b1;
    lr_b = rdy_b;

    repeat (20) begin
      tick_b();
      chk(1, "idle_sout", int'(so_b), 1);
      chk(1, "idle_valid", int'(sv_b), 0);
      chk(1, "idle_busy", int'(bz_b), 0);
    end

    per_b = 1;
    send_b(8'h01);
    repeat (20) tick_b();

    per_b = 0;
    repeat (300) begin
      if (!lv_b || acc_b) begin
        lv_b = ($urandom_range(0, 2) != 0);
        ld_b = 8'($urandom);
      end
      tick_b();
    end
    lv_b = 1'b0;
    per_b = 1;
    repeat (30) tick_b();
    chk(1, "drain", q[1].size(), 0);
    chk(1, "end_sout", int'(so_b), 1);
  endtask

  initial begin
    fork
      drive_a();
      drive_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
